// File: rtl/flasher_sequencer_if.sv
// Signal bundle between the host/flasher side and flasher_sequencer.
// FLASHER_SEQ_STATS_EN adds the total_runs statistics output.
interface flasher_sequencer_if;
  localparam int unsigned LED_W = 16;
  localparam int unsigned RC_W  = 4;
  localparam int unsigned TR_W  = 8;

  logic              start_req;
  logic [RC_W-1:0]   run_count;
  logic              kick_req;
  logic              abort;
  logic [LED_W-1:0]  led;
  logic              start_ack;
  logic              flick;
  logic              fl_rst_n;
  logic              busy;
  logic              done;
  logic              err;
`ifdef FLASHER_SEQ_STATS_EN
  logic [TR_W-1:0]   total_runs;

  modport master (
    output start_req, run_count, kick_req, abort, led,
    input  start_ack, flick, fl_rst_n, busy, done, err, total_runs
  );
  modport slave (
    input  start_req, run_count, kick_req, abort, led,
    output start_ack, flick, fl_rst_n, busy, done, err, total_runs
  );
`else
  modport master (
    output start_req, run_count, kick_req, abort, led,
    input  start_ack, flick, fl_rst_n, busy, done, err
  );
  modport slave (
    input  start_req, run_count, kick_req, abort, led,
    output start_ack, flick, fl_rst_n, busy, done, err
  );
`endif
endinterface

// File: rtl/flasher_sequencer.sv
// Run sequencer in front of bound_flasher: launches N flash sequences, injects kickbacks,
// watches the LED bus for completion/stall. FLASHER_SEQ_STATS_EN adds a completed-sequence counter.
module flasher_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter int unsigned TO_W        = 9
) (
  input  logic               clk,
  input  logic               rst,
  flasher_sequencer_if.slave bus
);
  localparam int unsigned LED_W = 16;
  localparam int unsigned RC_W  = 4;
  localparam logic [LED_W-1:0] KICK_HI = 16'h003F;
  localparam logic [LED_W-1:0] KICK_LO = 16'h0001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLRST,
    S_LAUNCH,
    S_RUN,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [RC_W-1:0]   remaining_q, remaining_d;
  logic              kick_pend_q, kick_pend_d;
  logic [TO_W-1:0]   stall_q, stall_d;
  logic [LED_W-1:0]  led_q;

  logic start_ack_q, start_ack_d;
  logic flick_q, flick_d;
  logic fl_rst_n_q, fl_rst_n_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic            led_chg;
  logic            in_win;
  logic            watching;
  logic [TO_W-1:0] stall_inc;
  logic            timeout;

  // LED activity and stall detection
  assign led_chg   = (bus.led != led_q);
  assign in_win    = (bus.led == KICK_HI) || (bus.led == KICK_LO);
  assign watching  = (state_q == S_LAUNCH) || (state_q == S_RUN);
  assign stall_inc = stall_q + TO_W'(1);
  assign timeout   = watching && !led_chg && (stall_inc == TO_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      kick_pend_q <= 1'b0;
      stall_q     <= '0;
      led_q       <= '0;
      start_ack_q <= 1'b0;
      flick_q     <= 1'b0;
      fl_rst_n_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      kick_pend_q <= kick_pend_d;
      stall_q     <= stall_d;
      led_q       <= bus.led;
      start_ack_q <= start_ack_d;
      flick_q     <= flick_d;
      fl_rst_n_q  <= fl_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Next state and next registered outputs; abort > timeout > completion > kick
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    kick_pend_d = kick_pend_q;
    stall_d     = '0;
    start_ack_d = 1'b0;
    flick_d     = 1'b0;
    fl_rst_n_d  = 1'b1;
    done_d      = 1'b0;
    err_d       = 1'b0;

    if ((state_q != S_IDLE) && bus.abort) begin
      state_d     = S_IDLE;
      fl_rst_n_d  = 1'b0;
      kick_pend_d = 1'b0;
    end else if (timeout) begin
      state_d    = S_ERR;
      err_d      = 1'b1;
      fl_rst_n_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start_req) begin
            remaining_d = (bus.run_count == '0) ? RC_W'(1) : bus.run_count;
            kick_pend_d = 1'b0;
            start_ack_d = 1'b1;
            fl_rst_n_d  = 1'b0;
            state_d     = S_FLRST;
          end
        end
        S_FLRST: begin
          flick_d = 1'b1;
          state_d = S_LAUNCH;
        end
        S_LAUNCH: begin
          if (bus.led != '0) state_d = S_RUN;
          else               flick_d = 1'b1;
        end
        S_RUN: begin
          if (bus.led == '0) begin
            remaining_d = remaining_q - RC_W'(1);
            if (remaining_q <= RC_W'(1)) begin
              done_d      = 1'b1;
              kick_pend_d = 1'b0;
              state_d     = S_IDLE;
            end else begin
              flick_d = 1'b1;
              state_d = S_LAUNCH;
            end
          end else begin
            // hold flick while inside the window; retire the kick once led moves on
            if (kick_pend_q && in_win)       flick_d     = 1'b1;
            else if (kick_pend_q && flick_q) kick_pend_d = 1'b0;
            if (bus.kick_req && !kick_pend_q) kick_pend_d = 1'b1;
          end
        end
        S_ERR: begin
          kick_pend_d = 1'b0;
          state_d     = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if ((state_d == state_q) && watching && !led_chg) stall_d = stall_inc;
    busy_d = (state_d != S_IDLE);
  end

  assign bus.start_ack = start_ack_q;
  assign bus.flick     = flick_q;
  assign bus.fl_rst_n  = fl_rst_n_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

`ifdef FLASHER_SEQ_STATS_EN
  localparam int unsigned TR_W = 8;
  logic [TR_W-1:0] total_runs_q;
  logic            run_cmpl;

  // one count per sequence completed in RUN, saturating
  assign run_cmpl = (state_q == S_RUN) && (bus.led == '0) && !bus.abort && !timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total_runs_q <= '0;
    end else if (run_cmpl && (total_runs_q != {TR_W{1'b1}})) begin
      total_runs_q <= total_runs_q + TR_W'(1);
    end
  end

  assign bus.total_runs = total_runs_q;
`endif
endmodule

// File: tb/tb_flasher_sequencer.sv
// Self-checking bench for flasher_sequencer with a simplified flasher model on the LED bus.
module tb_flasher_sequencer;
  localparam int TIMEOUT_CYC = 256;
  localparam int STEP        = 2;
  localparam int RUN_LIMIT   = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  flasher_sequencer_if bus ();

  flasher_sequencer #(.TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Flasher model: lamps fill up to all-on, drain to off; flick at 0x003F/0x0001 on the way down refills
  typedef enum logic [1:0] {PH_OFF, PH_UP, PH_DN} ph_t;
  ph_t         ph     = PH_OFF;
  logic [15:0] m_led  = '0;
  int          tick   = 0;
  int          n_seq  = 0;
  int          n_kick = 0;
  logic        ovr_en = 1'b0;
  logic [15:0] ovr_val = '0;

  assign bus.led = ovr_en ? ovr_val : m_led;

  always @(posedge clk) begin
    if (!bus.fl_rst_n) begin
      ph <= PH_OFF; m_led <= '0; tick <= 0;
    end else begin
      tick <= (tick + 1) % STEP;
      if (tick == STEP - 1) begin
        case (ph)
          PH_OFF: if (bus.flick) begin ph <= PH_UP; m_led <= 16'h0001; end
          PH_UP: begin
            m_led <= {m_led[14:0], 1'b1};
            if (m_led == 16'h7FFF) ph <= PH_DN;
          end
          PH_DN: begin
            if ((m_led == 16'h003F || m_led == 16'h0001) && bus.flick) begin
              ph <= PH_UP; m_led <= {m_led[14:0], 1'b1}; n_kick <= n_kick + 1;
            end else begin
              m_led <= m_led >> 1;
              if (m_led == 16'h0001) begin ph <= PH_OFF; n_seq <= n_seq + 1; end
            end
          end
          default: ph <= PH_OFF;
        endcase
      end
    end
  end

  // Pulse/low-cycle counters on the DUT outputs
  int n_done = 0, n_errp = 0, n_ack = 0, n_frst = 0;
  always @(negedge clk) begin
    if (rst) begin
      n_done <= n_done + (bus.done ? 1 : 0);
      n_errp <= n_errp + (bus.err ? 1 : 0);
      n_ack  <= n_ack + (bus.start_ack ? 1 : 0);
      n_frst <= n_frst + (bus.fl_rst_n ? 0 : 1);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic start_run(input logic [3:0] rc);
    @(negedge clk);
    bus.run_count = rc;
    bus.start_req = 1'b1;
    @(negedge clk);
    bus.start_req = 1'b0;
  endtask

  // nk=1: one kick past 0x00FF on the first ascent; nk=2: a second kick while pending
  task automatic run_and_wait(input logic [3:0] rc, input int nk, input bit rnd_kick,
                              output int pulses, output int ok);
    bit k1, k2;
    pulses = 0; ok = 0; k1 = 1'b0; k2 = 1'b0;
    start_run(rc);
    for (int c = 0; c < RUN_LIMIT; c++) begin
      @(negedge clk);
      bus.kick_req = 1'b0;
      if (bus.done || bus.err) begin ok = 1; break; end
      if (nk >= 1 && !k1 && bus.led == 16'h01FF) begin
        bus.kick_req = 1'b1; k1 = 1'b1; pulses++;
      end else if (nk >= 2 && k1 && !k2 && bus.led == 16'h0FFF) begin
        bus.kick_req = 1'b1; k2 = 1'b1; pulses++;
      end else if (rnd_kick && pulses < 4 && $urandom_range(0, 63) == 0) begin
        bus.kick_req = 1'b1; pulses++;
      end
    end
    bus.kick_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] rc;
    int         nk;
    int         exp_seq;
    int         exp_kick;
  } vec_t;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int s_seq, s_kick, s_done, s_errp, s_ack, s_frst;
    int pulses, ok, cnt, hit;
    int exp_seq;
    logic [3:0] rc;
    logic [15:0] prev;

    vecs[0] = '{rc: 4'd1,  nk: 0, exp_seq: 1,  exp_kick: 0};
    vecs[1] = '{rc: 4'd3,  nk: 0, exp_seq: 3,  exp_kick: 0};
    vecs[2] = '{rc: 4'd0,  nk: 0, exp_seq: 1,  exp_kick: 0};
    vecs[3] = '{rc: 4'd2,  nk: 1, exp_seq: 2,  exp_kick: 1};
    vecs[4] = '{rc: 4'd1,  nk: 2, exp_seq: 1,  exp_kick: 1};
    vecs[5] = '{rc: 4'd15, nk: 0, exp_seq: 15, exp_kick: 0};

    bus.start_req = 1'b0; bus.run_count = '0; bus.kick_req = 1'b0; bus.abort = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    // reset values
    chk("rst_start_ack", int'(bus.start_ack), 0);
    chk("rst_flick", int'(bus.flick), 0);
    chk("rst_fl_rst_n", int'(bus.fl_rst_n), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
`ifdef FLASHER_SEQ_STATS_EN
    chk("rst_total_runs", int'(bus.total_runs), 0);
`endif

    // single run, cycle by cycle
    rst = 1'b1;
    #1 chk("release_fl_rst_n_still_low", int'(bus.fl_rst_n), 0);
    @(negedge clk);
    chk("first_clk_fl_rst_n", int'(bus.fl_rst_n), 1);
    start_run(4'd1);
    chk("t1_start_ack", int'(bus.start_ack), 1);
    chk("t1_flrst_low", int'(bus.fl_rst_n), 0);
    chk("t1_busy", int'(bus.busy), 1);
    @(negedge clk);
    chk("t1_ack_pulse", int'(bus.start_ack), 0);
    chk("t1_fl_rst_n_back", int'(bus.fl_rst_n), 1);
    chk("t1_flick_launch", int'(bus.flick), 1);
    hit = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.led != 16'h0000) begin hit = 1; break; end
      @(negedge clk);
    end
    chk("t1_led_started", hit, 1);
    chk("t1_led_first", int'(bus.led), 16'h0001);
    @(negedge clk);
    chk("t1_flick_dropped", int'(bus.flick), 0);
    hit = 0;
    for (int c = 0; c < RUN_LIMIT; c++) begin
      @(negedge clk);
      if (bus.done) begin hit = 1; break; end
    end
    chk("t1_done_seen", hit, 1);
    chk("t1_led_at_done", int'(bus.led), 0);
    @(negedge clk);
    chk("t1_busy_after_done", int'(bus.busy), 0);
    chk("t1_done_pulse", int'(bus.done), 0);

    // table-driven runs
    for (int i = 0; i < 6; i++) begin
      s_seq = n_seq; s_kick = n_kick; s_done = n_done; s_errp = n_errp; s_ack = n_ack; s_frst = n_frst;
      run_and_wait(vecs[i].rc, vecs[i].nk, 1'b0, pulses, ok);
      chk($sformatf("tbl%0d_finished", i), ok, 1);
      chk($sformatf("tbl%0d_sequences", i), n_seq - s_seq, vecs[i].exp_seq);
      chk($sformatf("tbl%0d_kicks", i), n_kick - s_kick, vecs[i].exp_kick);
      chk($sformatf("tbl%0d_done", i), n_done - s_done, 1);
      chk($sformatf("tbl%0d_err", i), n_errp - s_errp, 0);
      chk($sformatf("tbl%0d_ack", i), n_ack - s_ack, 1);
      chk($sformatf("tbl%0d_flrst_cycles", i), n_frst - s_frst, 1);
      chk($sformatf("tbl%0d_busy_idle", i), int'(bus.busy), 0);
    end

    // stall: led frozen at 0x0007 during RUN
    s_done = n_done;
    start_run(4'd1);
    hit = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.led == 16'h0003) begin hit = 1; break; end
    end
    chk("stall_reached_run", hit, 1);
    ovr_val = 16'h0007; ovr_en = 1'b1;
    cnt = 0; hit = 0;
    for (int c = 0; c < TIMEOUT_CYC + 20; c++) begin
      @(negedge clk);
      cnt++;
      if (bus.err) begin hit = 1; break; end
    end
    chk("stall_err_seen", hit, 1);
    chk("stall_latency_ok", (cnt >= TIMEOUT_CYC && cnt <= TIMEOUT_CYC + 2) ? 1 : 0, 1);
    chk("stall_fl_rst_n", int'(bus.fl_rst_n), 0);
    @(negedge clk);
    ovr_en = 1'b0;
    chk("stall_busy", int'(bus.busy), 0);
    chk("stall_err_pulse", int'(bus.err), 0);
    repeat (2) @(negedge clk);
    chk("stall_no_done", n_done - s_done, 0);

    // abort on the same cycle that led returns to zero
    s_done = n_done; s_errp = n_errp;
    start_run(4'd1);
    prev = 16'hFFFF; hit = 0;
    for (int c = 0; c < RUN_LIMIT; c++) begin
      @(negedge clk);
      if (prev == 16'h0001 && bus.led == 16'h0000) begin bus.abort = 1'b1; hit = 1; break; end
      prev = bus.led;
    end
    chk("abort_hit", hit, 1);
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_fl_rst_n", int'(bus.fl_rst_n), 0);
    chk("abort_flick", int'(bus.flick), 0);
    chk("abort_busy", int'(bus.busy), 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", n_done - s_done, 0);
    chk("abort_no_err", n_errp - s_errp, 0);
    chk("abort_fl_rst_n_back", int'(bus.fl_rst_n), 1);

    // async reset in LAUNCH (flasher held silent)
    ovr_val = 16'h0000; ovr_en = 1'b1;
    start_run(4'd2);
    hit = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.flick) begin hit = 1; break; end
    end
    chk("rst_mid_launch_flick", hit, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_fl_rst_n", int'(bus.fl_rst_n), 0);
    chk("rst_mid_flick", int'(bus.flick), 0);
    chk("rst_mid_busy", int'(bus.busy), 0);
    chk("rst_mid_done", int'(bus.done), 0);
    chk("rst_mid_ack", int'(bus.start_ack), 0);
    @(negedge clk);
    rst = 1'b1;
    ovr_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_idle_busy", int'(bus.busy), 0);

    // randomized runs against the sequence-count reference
    for (int i = 0; i < 12; i++) begin
      rc = 4'($urandom_range(0, 4));
      exp_seq = (rc == 4'd0) ? 1 : int'(rc);
      s_seq = n_seq; s_kick = n_kick; s_done = n_done; s_errp = n_errp;
      run_and_wait(rc, 0, 1'b1, pulses, ok);
      chk($sformatf("rnd%0d_finished", i), ok, 1);
      chk($sformatf("rnd%0d_sequences", i), n_seq - s_seq, exp_seq);
      chk($sformatf("rnd%0d_done", i), n_done - s_done, 1);
      chk($sformatf("rnd%0d_err", i), n_errp - s_errp, 0);
      chk($sformatf("rnd%0d_kicks_le_req", i), (n_kick - s_kick <= pulses) ? 1 : 0, 1);
    end

`ifdef FLASHER_SEQ_STATS_EN
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("stats_reset", int'(bus.total_runs), 0);
    rst = 1'b1;
    @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 2; i++) begin
      run_and_wait(4'd3, 0, 1'b0, pulses, ok);
      cnt += 3;
    end
    chk("stats_six", int'(bus.total_runs), (cnt > 255) ? 255 : cnt);
    for (int i = 0; i < 20; i++) begin
      run_and_wait(4'd15, 0, 1'b0, pulses, ok);
      cnt += 15;
    end
    chk("stats_saturate", int'(bus.total_runs), (cnt > 255) ? 255 : cnt);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
